// File: rtl/adc_pipe_pkg.sv
// Shared constants for the pipelined add/subtract-with-carry unit.
package adc_pipe_pkg;

    localparam int unsigned ADC_WIDTH_DEF = 32;
    localparam int unsigned ADC_SEG_DEF   = 8;

    localparam logic ADC_OP_ADD = 1'b0;
    localparam logic ADC_OP_SUB = 1'b1;

    // Pipeline depth for a given operand width and segment width.
    function automatic int unsigned adc_stages(input int unsigned width, input int unsigned seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/adc_pipe_if.sv
// Operand/result handshake bundle for adc_pipe.
interface adc_pipe_if
    import adc_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = ADC_WIDTH_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    // The arithmetic unit itself.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

    // Operand producer / result consumer.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

endinterface

// File: rtl/adc_pipe_seg.sv
// One SEG-bit slice of the carry chain: sum, carry out, carry into the top bit, zero.
module adc_pipe_seg
    import adc_pipe_pkg::*;
#(
    parameter int unsigned SEG = ADC_SEG_DEF
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] bb_i,
    input  logic           ci_i,
    output logic [SEG-1:0] s_o,
    output logic           co_o,
    output logic           cmsb_o,
    output logic           z_o
);

    logic [SEG:0] full_c;

    // Segment add with carry; carry into the MSB recovered as a^b^s at that bit.
    assign full_c = {1'b0, a_i} + {1'b0, bb_i} + (SEG+1)'(ci_i);
    assign s_o    = full_c[SEG-1:0];
    assign co_o   = full_c[SEG];
    assign cmsb_o = a_i[SEG-1] ^ bb_i[SEG-1] ^ full_c[SEG-1];
    assign z_o    = ~|full_c[SEG-1:0];

endmodule

// File: rtl/adc_pipe.sv
// Pipelined add/subtract-with-carry: one SEG-bit carry segment resolved per stage,
// global stall when the output register is full and not accepted.
module adc_pipe
    import adc_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = ADC_WIDTH_DEF,
    parameter int unsigned SEG   = ADC_SEG_DEF
) (
    input  logic      clk,
    input  logic      rst,
    adc_pipe_if.slave io
);

    localparam int unsigned STAGES = adc_stages(WIDTH, SEG);

    if ((WIDTH % SEG) != 0) begin : g_bad_cfg
        $error("adc_pipe: WIDTH must be an integer multiple of SEG");
    end

    logic             en;

    // Values entering each stage register (from the port for stage 0).
    logic             v_d    [STAGES];
    logic [WIDTH-1:0] a_d    [STAGES];
    logic [WIDTH-1:0] bb_d   [STAGES];
    logic [WIDTH-1:0] s_in   [STAGES];
    logic             c_in   [STAGES];
    logic             z_in   [STAGES];
    logic [WIDTH-1:0] sum_d  [STAGES];

    // Segment adder outputs.
    logic [SEG-1:0]   s_c    [STAGES];
    logic             co_c   [STAGES];
    logic             cmsb_c [STAGES];
    logic             z_c    [STAGES];

    // Stage registers; the last one is the output register.
    logic             v_q    [STAGES];
    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] bb_q   [STAGES];
    logic [WIDTH-1:0] sum_q  [STAGES];
    logic             c_q    [STAGES];
    logic             z_q    [STAGES];
    logic             ovf_d;
    logic             ovf_q;

    // Whole pipe advances together unless a held result blocks the output.
    assign en          = ~v_q[STAGES-1] | io.out_ready;
    assign io.in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage

        localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}}) << (k*SEG);

        if (k == 0) begin : g_head
            // First stage takes the beat straight from the port; B inverted for subtract.
            assign v_d[k]  = io.in_valid;
            assign a_d[k]  = io.a;
            assign bb_d[k] = (io.sub == ADC_OP_SUB) ? ~io.b : io.b;
            assign s_in[k] = '0;
            assign c_in[k] = io.cin;
            assign z_in[k] = 1'b1;
        end else begin : g_body
            // Later stages continue the beat held in the previous stage register.
            assign v_d[k]  = v_q[k-1];
            assign a_d[k]  = a_q[k-1];
            assign bb_d[k] = bb_q[k-1];
            assign s_in[k] = sum_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign z_in[k] = z_q[k-1];
        end

        adc_pipe_seg #(
            .SEG (SEG)
        ) u_seg (
            .a_i    (a_d[k][k*SEG +: SEG]),
            .bb_i   (bb_d[k][k*SEG +: SEG]),
            .ci_i   (c_in[k]),
            .s_o    (s_c[k]),
            .co_o   (co_c[k]),
            .cmsb_o (cmsb_c[k]),
            .z_o    (z_c[k])
        );

        // Drop this stage's segment into the travelling partial sum.
        assign sum_d[k] = (s_in[k] & ~SEG_MASK) | (WIDTH'(s_c[k]) << (k*SEG));

        // Stage register: holds (bubbles included) while the pipe is stalled.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q[k]   <= 1'b0;
                a_q[k]   <= '0;
                bb_q[k]  <= '0;
                sum_q[k] <= '0;
                c_q[k]   <= 1'b0;
                z_q[k]   <= 1'b0;
            end else if (en) begin
                v_q[k]   <= v_d[k];
                a_q[k]   <= a_d[k];
                bb_q[k]  <= bb_d[k];
                sum_q[k] <= sum_d[k];
                c_q[k]   <= co_c[k];
                z_q[k]   <= z_in[k] & z_c[k];
            end
        end
    end

    // Signed overflow: carry into the sign bit differs from carry out.
    assign ovf_d = cmsb_c[STAGES-1] ^ co_c[STAGES-1];

    // Overflow is only known at the last segment, so it lives beside the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf_d;
        end
    end

    assign io.out_valid = v_q[STAGES-1];
    assign io.sum       = sum_q[STAGES-1];
    assign io.cout      = c_q[STAGES-1];
    assign io.zero      = z_q[STAGES-1];
    assign io.ovf       = ovf_q;

endmodule
